// File: rtl/buscador_pkg.sv
// Shared constants and FSM state type for the key search block.
package buscador_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } estado_t;

endpackage

// File: rtl/tabla_claves.sv
// Key table: stored keys plus valid bits, one write port and a combinational
// read port driven by the search index. Reset and clear touch only valid bits.
module tabla_claves #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_key,
    input  logic                     clr_all,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_key,
    output logic                     rd_valid
);

    logic [WIDTH-1:0] claves [DEPTH];
    logic [DEPTH-1:0] validos;

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            validos <= '0;
        end else if (wr_en) begin
            validos[wr_idx] <= 1'b1;
        end
    end

    // Keys carry no reset; a cleared entry is simply marked invalid.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) begin
            claves[wr_idx] <= wr_key;
        end
    end

    assign rd_key   = claves[rd_idx];
    assign rd_valid = validos[rd_idx];

endmodule

// File: rtl/buscador_claves.sv
// Sequential key search over a small table, one entry per cycle.
// Define BUSCADOR_CONTEO_EN to scan the whole table and count all matches.
//
// state   | meaning
// IDLE    | waiting for start; table writes/clears accepted
// COMPARA | comparing entry idx against the latched target
// FIN     | one-cycle done pulse, results held afterwards
module buscador_claves
    import buscador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_key,
    input  logic                     clr_all,
    input  logic                     start,
    input  logic [WIDTH-1:0]         target,
    output logic                     busy,
    output logic                     done,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] hit_idx,
    output logic [$clog2(DEPTH):0]   match_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] ULTIMO = IW'(DEPTH - 1);
    localparam logic [IW:0]   UNO    = (IW + 1)'(1);

    estado_t          estado;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] objetivo;
    logic [WIDTH-1:0] rd_key;
    logic             rd_valid;
    logic             coincide;
    logic             ocioso;
    logic             termina;

    assign ocioso   = (estado == IDLE);
    assign coincide = rd_valid && (rd_key == objetivo);

`ifdef BUSCADOR_CONTEO_EN
    assign termina = (idx == ULTIMO);
`else
    assign termina = coincide || (idx == ULTIMO);
`endif

    tabla_claves #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tabla (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en && ocioso),
        .wr_idx   (wr_idx),
        .wr_key   (wr_key),
        .clr_all  (clr_all && ocioso),
        .rd_idx   (idx),
        .rd_key   (rd_key),
        .rd_valid (rd_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= IDLE;
            idx       <= '0;
            objetivo  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            match_cnt <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        estado    <= COMPARA;
                        busy      <= 1'b1;
                        objetivo  <= target;
                        idx       <= '0;
                        hit       <= 1'b0;
                        hit_idx   <= '0;
                        match_cnt <= '0;
                    end
                end
                COMPARA: begin
                    if (coincide) begin
                        // Ascending scan: the first match seen is the lowest index.
                        if (!hit) begin
                            hit     <= 1'b1;
                            hit_idx <= idx;
                        end
`ifdef BUSCADOR_CONTEO_EN
                        match_cnt <= match_cnt + UNO;
`else
                        match_cnt <= UNO;
`endif
                    end
                    if (termina) begin
                        estado <= FIN;
                        done   <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    estado <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
                default: begin
                    estado <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buscador_claves.sv
// Directed plus randomized checks of buscador_claves against a table model
// that computes hit, lowest index, count and latency from the stored entries.
module tb_buscador_claves;

    localparam int WIDTH = 5;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [IW-1:0]    wr_idx = '0;
    logic [WIDTH-1:0] wr_key = '0;
    logic             clr_all = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] target = '0;
    logic             busy;
    logic             done;
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic [IW:0]      match_cnt;

    int nchk = 0;
    int nerr = 0;

    logic [WIDTH-1:0] m_key   [DEPTH];
    bit               m_valid [DEPTH];

    buscador_claves #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .clr_all   (clr_all),
        .start     (start),
        .target    (target),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    task automatic write(input logic [IW-1:0] i, input logic [WIDTH-1:0] k, input bit clr);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = i; wr_key = k; clr_all = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; clr_all = 1'b0;
        if (clr) model_clear();
        else begin
            m_key[i]   = k;
            m_valid[i] = 1'b1;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_hit"}, 32'(hit), 0);
        check({tag, "_hit_idx"}, 32'(hit_idx), 0);
        check({tag, "_match_cnt"}, 32'(match_cnt), 0);
    endtask

    // Optional write coincident with start; optional start+write while busy.
    task automatic search(input string tag, input logic [WIDTH-1:0] t, input bit interfere,
                          input bit pre_wr, input logic [IW-1:0] pidx, input logic [WIDTH-1:0] pkey);
        int n;
        int cnt;
        int first;
        int exp_lat;
        int ndone;
        int nbusy;
        @(negedge clk);
        start = 1'b1; target = t;
        if (pre_wr) begin
            wr_en = 1'b1; wr_idx = pidx; wr_key = pkey;
            m_key[pidx] = pkey; m_valid[pidx] = 1'b1;
        end
        cnt = 0; first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_key[i] == t) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef BUSCADOR_CONTEO_EN
        exp_lat = DEPTH;
`else
        exp_lat = (first >= 0) ? first + 1 : DEPTH;
        cnt = (cnt > 0) ? 1 : 0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0; wr_en = 1'b0;
        n = 0;
        while (n < 2 * DEPTH + 4) begin
            if (interfere && n == 0) begin
                @(negedge clk);
                start = 1'b1; target = ~t; wr_en = 1'b1; wr_idx = '0; wr_key = 5'h1F;
            end
            @(posedge clk);
            n++;
            #1;
            start = 1'b0; wr_en = 1'b0;
            if (done === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 1);
        check({tag, "_hit"}, 32'(hit), (first >= 0) ? 1 : 0);
        check({tag, "_hit_idx"}, 32'(hit_idx), (first >= 0) ? 32'(first) : 0);
        check({tag, "_match_cnt"}, 32'(match_cnt), 32'(cnt));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_hit_held"}, 32'(hit), (first >= 0) ? 1 : 0);
        if (interfere) begin
            ndone = 0; nbusy = 0;
            for (int c = 0; c < DEPTH + 2; c++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) ndone++;
                if (busy === 1'b1) nbusy++;
            end
            check({tag, "_no_second_done"}, 32'(ndone), 0);
            check({tag, "_no_restart"}, 32'(nbusy), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_key[i] = '0;
        model_clear();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("reset");

        search("empty", 5'h00, 0, 0, '0, '0);

        write(3, 5'h0A, 0);
        search("single_hit", 5'h0A, 0, 0, '0, '0);

        write(1, 5'h11, 0);
        write(6, 5'h11, 0);
        search("double_hit", 5'h11, 0, 0, '0, '0);

        search("busy_ignore", 5'h0A, 1, 0, '0, '0);
        search("busy_write_lost", 5'h1F, 0, 0, '0, '0);

        write(2, 5'h15, 1);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 2; wr_key = 5'h15; clr_all = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; clr_all = 1'b0;
        model_clear();
        search("clr_priority", 5'h15, 0, 0, '0, '0);

        write(5, 5'h07, 0);
        @(negedge clk);
        start = 1'b1; target = 5'h07;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_idle_zero("mid_reset");
        search("after_reset", 5'h07, 0, 0, '0, '0);

        search("write_with_start", 5'h1C, 0, 1, 3'd0, 5'h1C);

        for (int r = 0; r < 24; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                write(IW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom_range(0, 3)),
                      ($urandom_range(0, 15) == 0));
            end
            search($sformatf("rand%0d", r), WIDTH'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), 0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/buscador_claves.md
BUSCADOR_CLAVES -- requirements
Module: buscador_claves

Interface
REQ-001 SHALL have parameter WIDTH, default 5, key width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of key-table entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write strobe for one table entry.
REQ-006 SHALL have port wr_idx  input  $clog2(DEPTH)  entry written.
REQ-007 SHALL have port wr_key  input  WIDTH  key written; entry marked valid.
REQ-008 SHALL have port clr_all  input  1  invalidates all entries.
REQ-009 SHALL have port start  input  1  search request.
REQ-010 SHALL have port target  input  WIDTH  key searched; sampled with start.
REQ-011 SHALL have port busy  output  1  high while a search is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at search completion.
REQ-013 SHALL have port hit  output  1  at least one valid entry equals target.
REQ-014 SHALL have port hit_idx  output  $clog2(DEPTH)  lowest matching index.
REQ-015 SHALL have port match_cnt  output  $clog2(DEPTH)+1  number of matching valid entries.

Function
REQ-016 SHALL implement FSM states IDLE, COMPARA, FIN: IDLE->COMPARA on start; COMPARA->FIN on termination; FIN->IDLE unconditionally after one cycle.
REQ-017 SHALL in COMPARA evaluate exactly one entry per cycle, indices ascending from 0, via full WIDTH-bit equality against the latched target.
REQ-018 SHALL treat invalid entries as non-matching, regardless of stored key.
REQ-019 SHALL assert busy in COMPARA and FIN; done only in FIN.
REQ-020 SHALL (first-hit mode) terminate COMPARA on the cycle that compares the first match; done goes high i+1 cycles after the edge sampling start, for a hit at index i; on a miss, DEPTH cycles after.
REQ-021 SHALL hold hit, hit_idx and match_cnt stable from done until the next accepted start; hit_idx = 0 when hit = 0.
REQ-022 SHALL ignore start while busy = 1; no queuing.
REQ-023 SHALL ignore wr_en and clr_all while busy = 1; in IDLE, a write coincident with start takes effect first, so the search sees the new value.
REQ-024 SHALL give clr_all priority over wr_en in the same cycle.
REQ-025 SHALL not wrap the index counter past DEPTH-1; reaching it without termination ends the search.

Reset
REQ-026 SHALL on rst (any state, including mid-search) force IDLE, clear all valid bits, and drive busy, done, hit, hit_idx, match_cnt to 0 on the following edge.
REQ-027 SHALL not reset stored key values; only valid bits.

Configuration
REQ-028 SHALL support macro BUSCADOR_CONTEO_EN.
REQ-029 SHALL, with BUSCADOR_CONTEO_EN defined, always scan all DEPTH entries (done exactly DEPTH cycles after start), count matches into match_cnt, with hit_idx = lowest match.
REQ-030 SHALL, without BUSCADOR_CONTEO_EN, use first-hit termination (REQ-020) and drive match_cnt = hit (0 or 1).

Structure
REQ-031 SHALL place the FSM state enum and the default WIDTH/DEPTH constants in package buscador_pkg.
REQ-032 SHALL place the key and valid storage, with its write and clear logic, in sub-module tabla_claves, with a combinational read port indexed by the scan counter.

Verification
REQ-033 SHALL cover: write key 5'h0A at idx 3, start, target 5'h0A -> done 4 cycles after start, hit=1, hit_idx=3, match_cnt=1 (DEPTH cycles and match_cnt=1 with macro).
REQ-034 SHALL cover: empty table, start, target 5'h00 -> done 8 cycles after start, hit=0, hit_idx=0, match_cnt=0.
REQ-035 SHALL cover: key 5'h11 at idx 1 and 6, with macro -> hit_idx=1, match_cnt=2; without macro -> done 2 cycles after start, match_cnt=1.
REQ-036 SHALL cover: start pulsed again and wr_en to idx 0 during busy -> no restart; table unchanged; single done.
REQ-037 SHALL cover: rst asserted 2 cycles into a search -> next edge busy=0, done=0, hit=0; a later search on the same target misses.
REQ-038 SHALL cover: clr_all with wr_en same cycle, then search the written key -> hit=0.
